rep_seq_scheduler: RTL and testbench

//  Programmable sequencer that drives the a/b/c stimulus protocol checked by the

---
 rtl/rep_seq_pkg.sv | 30 +++
 rtl/rep_seq_scheduler_if.sv | 29 ++
 rtl/rep_seq_cnt.sv | 28 ++
 rtl/rep_seq_scheduler.sv | 166 ++++++++++++++++
 tb/tb_rep_seq_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rep_seq_pkg.sv
// Shared types for the a/b/c repetition sequencer.
// Modes, FSM states, burst sub-phases and request validation.
package rep_seq_pkg;

    typedef enum logic [1:0] {
        CONSEC    = 2'd0,
        NONCONSEC = 2'd1,
        GOTO      = 2'd2,
        RSVD      = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT,
        BURST,
        TERM
    } state_e;

    typedef enum logic {
        PH_GAP,
        PH_PULSE
    } phase_e;

    function automatic logic req_valid(input logic [1:0] m,
                                       input logic n_nz);
        return (mode_e'(m) != RSVD) && n_nz;
    endfunction

endpackage

// File: rtl/rep_seq_scheduler_if.sv
// Config-side request and DUT-side a/b/c bundle.
// master drives requests, slave is the sequencer.
interface rep_seq_scheduler_if #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
);

    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] rep_n;
    logic [GAP_W-1:0] gap;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, mode, rep_n, gap,
        input  a, b, c, busy, done, err
    );

    modport slave (
        input  start, mode, rep_n, gap,
        output a, b, c, busy, done, err
    );

endinterface

// File: rtl/rep_seq_cnt.sv
// Loadable saturating down-counter.
// Load wins over decrement; holds at zero.
module rep_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load has priority; decrement never wraps below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rep_seq_scheduler.sv
// a/b/c stimulus sequencer: trigger, idle, b burst, terminator.
// One sequence in flight; all outputs registered.
module rep_seq_scheduler #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    rep_seq_scheduler_if.slave bus
);

    import rep_seq_pkg::*;

    state_e           state_q;
    state_e           state_d;
    phase_e           phase_q;
    phase_e           phase_d;
    mode_e            mode_q;
    logic [GAP_W-1:0] gap_q;

    logic cfg_en;
    logic p_load;
    logic p_dec;
    logic p_zero;
    logic g_load;
    logic g_dec;
    logic g_zero;
    logic consec;

    logic a_q, b_q, c_q, busy_q, done_q, err_q;
    logic a_d, b_d, c_d, busy_d, done_d, err_d;

    // gap of zero collapses the spaced modes onto back-to-back pulses
    assign consec = (mode_q == CONSEC) || (gap_q == '0);

    // pulses still to emit after the current one
    rep_seq_cnt #(.W(CNT_W)) u_pulse_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (p_load),
        .load_val (bus.rep_n),
        .dec      (p_dec),
        .zero     (p_zero)
    );

    // gap cycles still to spend after the current one
    rep_seq_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (g_load),
        .load_val (gap_q - GAP_W'(1)),
        .dec      (g_dec),
        .zero     (g_zero)
    );

    // next state, counter controls and next output values
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cfg_en  = 1'b0;
        p_load  = 1'b0;
        p_dec   = 1'b0;
        g_load  = 1'b0;
        g_dec   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (req_valid(bus.mode, bus.rep_n != '0)) begin
                        state_d = TRIG;
                        cfg_en  = 1'b1;
                        p_load  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            TRIG: state_d = WAIT;
            WAIT: begin
                state_d = BURST;
                if (mode_q == GOTO && !consec) begin
                    phase_d = PH_GAP;
                    g_load  = 1'b1;
                end else begin
                    phase_d = PH_PULSE;
                    p_dec   = 1'b1;
                end
            end
            BURST: begin
                if (phase_q == PH_PULSE) begin
                    if (p_zero && (consec || mode_q == GOTO)) begin
                        state_d = TERM;
                    end else if (consec) begin
                        p_dec = 1'b1;
                    end else begin
                        phase_d = PH_GAP;
                        g_load  = 1'b1;
                    end
                end else if (!g_zero) begin
                    g_dec = 1'b1;
                end else if (mode_q == NONCONSEC && p_zero) begin
                    state_d = TERM;
                end else begin
                    phase_d = PH_PULSE;
                    p_dec   = 1'b1;
                end
            end
            TERM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        a_d    = (state_d == TRIG);
        b_d    = (state_d == BURST) && (phase_d == PH_PULSE);
        c_d    = (state_d == TERM);
        done_d = c_d;
        busy_d = (state_d != IDLE);
    end

    // FSM state and burst sub-phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH_GAP;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // request configuration captured on acceptance only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= CONSEC;
            gap_q  <= '0;
        end else if (cfg_en) begin
            mode_q <= mode_e'(bus.mode);
            gap_q  <= bus.gap;
        end
    end

    // registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            c_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.c    = c_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_rep_seq_scheduler.sv
// Directed bench for rep_seq_scheduler.
// Per-cycle traces are packed into masks (bit k = cycle k after start).
module tb_rep_seq_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rep_seq_scheduler_if #(.CNT_W(4), .GAP_W(4)) bus ();

    rep_seq_scheduler #(.CNT_W(4), .GAP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] oa, ob, oc, obusy, odone, oerr;
    int nb, fb, cc;

    // a, b and c must never overlap
    always @(negedge clk) begin
        vectors++;
        if ($countones({bus.a, bus.b, bus.c}) > 1) begin
            miscompares++;
            $display("FAIL onehot t=%0t: got abc=%b want at most one high",
                     $time, {bus.a, bus.b, bus.c});
        end
    end

    task automatic capture(input logic [1:0] m, input logic [3:0] n,
                           input logic [3:0] g, input int ncyc,
                           input bit hold);
        oa = '0; ob = '0; oc = '0;
        obusy = '0; odone = '0; oerr = '0;
        nb = 0; fb = 0; cc = 0;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.rep_n = n;
        bus.gap   = g;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            if (k < 64) begin
                oa[k]    = bus.a;
                ob[k]    = bus.b;
                oc[k]    = bus.c;
                obusy[k] = bus.busy;
                odone[k] = bus.done;
                oerr[k]  = bus.err;
            end
            if (bus.b) begin
                nb++;
                if (fb == 0) fb = k;
            end
            if (bus.c && cc == 0) cc = k;
            if (!hold) begin
                bus.start = 1'b0;
                bus.mode  = 2'd3;
                bus.rep_n = 4'd0;
                bus.gap   = 4'd15;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 2'd0; bus.rep_n = 4'd0; bus.gap = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.a, bus.b, bus.c, bus.busy, bus.done, bus.err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {bus.a, bus.b, bus.c, bus.busy, bus.done, bus.err});
        end
        rst = 1'b0;
    endtask

    task automatic test_consec;
        capture(2'd0, 4'd3, 4'd9, 8, 1'b0);
        vectors++;
        if ({oa, ob, oc} !== {64'h2, 64'h38, 64'h40}) begin
            miscompares++;
            $display("FAIL consec_abc: got a=%h b=%h c=%h want a=2 b=38 c=40", oa, ob, oc);
        end
        vectors++;
        if ({obusy, odone, oerr} !== {64'h7E, 64'h40, 64'h0}) begin
            miscompares++;
            $display("FAIL consec_stat: got busy=%h done=%h err=%h want 7e 40 0", obusy, odone, oerr);
        end
    endtask

    task automatic test_nonconsec;
        capture(2'd1, 4'd2, 4'd1, 9, 1'b0);
        vectors++;
        if ({oa, ob, oc} !== {64'h2, 64'h28, 64'h80}) begin
            miscompares++;
            $display("FAIL nonconsec_abc: got a=%h b=%h c=%h want a=2 b=28 c=80", oa, ob, oc);
        end
        vectors++;
        if ({obusy, odone, oerr} !== {64'hFE, 64'h80, 64'h0}) begin
            miscompares++;
            $display("FAIL nonconsec_stat: got busy=%h done=%h err=%h want fe 80 0", obusy, odone, oerr);
        end
    endtask

    task automatic test_goto;
        capture(2'd2, 4'd2, 4'd2, 11, 1'b0);
        vectors++;
        if ({oa, ob, oc} !== {64'h2, 64'h120, 64'h200}) begin
            miscompares++;
            $display("FAIL goto_abc: got a=%h b=%h c=%h want a=2 b=120 c=200", oa, ob, oc);
        end
        vectors++;
        if ({obusy, odone, oerr} !== {64'h3FE, 64'h200, 64'h0}) begin
            miscompares++;
            $display("FAIL goto_stat: got busy=%h done=%h err=%h want 3fe 200 0", obusy, odone, oerr);
        end
    endtask

    task automatic test_gap_zero;
        capture(2'd1, 4'd2, 4'd0, 7, 1'b0);
        vectors++;
        if ({oa, ob, oc, obusy} !== {64'h2, 64'h18, 64'h20, 64'h3E}) begin
            miscompares++;
            $display("FAIL gap0_nonconsec: got a=%h b=%h c=%h busy=%h want 2 18 20 3e", oa, ob, oc, obusy);
        end
        capture(2'd2, 4'd2, 4'd0, 7, 1'b0);
        vectors++;
        if ({oa, ob, oc, obusy} !== {64'h2, 64'h18, 64'h20, 64'h3E}) begin
            miscompares++;
            $display("FAIL gap0_goto: got a=%h b=%h c=%h busy=%h want 2 18 20 3e", oa, ob, oc, obusy);
        end
    endtask

    task automatic test_invalid;
        capture(2'd0, 4'd0, 4'd1, 4, 1'b0);
        vectors++;
        if ({oa, ob, oc, obusy, odone, oerr} !== {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h2}) begin
            miscompares++;
            $display("FAIL invalid_n0: got a=%h b=%h c=%h busy=%h done=%h err=%h want err=2 rest 0",
                     oa, ob, oc, obusy, odone, oerr);
        end
        capture(2'd3, 4'd2, 4'd1, 4, 1'b0);
        vectors++;
        if ({oa, ob, oc, obusy, odone, oerr} !== {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h2}) begin
            miscompares++;
            $display("FAIL invalid_rsvd: got a=%h b=%h c=%h busy=%h done=%h err=%h want err=2 rest 0",
                     oa, ob, oc, obusy, odone, oerr);
        end
    endtask

    task automatic test_mid_reset;
        int bad;
        bus.start = 1'b1; bus.mode = 2'd0; bus.rep_n = 4'd4; bus.gap = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        vectors++;
        if ({bus.a, bus.b, bus.c, bus.busy} !== 4'b0101) begin
            miscompares++;
            $display("FAIL midrst_before: got abc_busy=%b want 0101",
                     {bus.a, bus.b, bus.c, bus.busy});
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.a, bus.b, bus.c, bus.busy, bus.done, bus.err} !== 6'b0) begin
            miscompares++;
            $display("FAIL midrst_async: got %b want 000000",
                     {bus.a, bus.b, bus.c, bus.busy, bus.done, bus.err});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.a || bus.b || bus.c || bus.busy || bus.done || bus.err) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: got %0d active cycles want 0", bad);
        end
        capture(2'd0, 4'd4, 4'd0, 9, 1'b0);
        vectors++;
        if ({oa, ob, oc, obusy, odone} !== {64'h2, 64'h78, 64'h80, 64'hFE, 64'h80}) begin
            miscompares++;
            $display("FAIL midrst_rerun: got a=%h b=%h c=%h busy=%h done=%h want 2 78 80 fe 80",
                     oa, ob, oc, obusy, odone);
        end
    endtask

    task automatic drain(input string tag);
        bit idle;
        idle = 1'b0;
        bus.start = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) idle = 1'b1;
        end
        vectors++;
        if (!idle) begin
            miscompares++;
            $display("FAIL %s_drain: got busy=1 after 300 cycles want 0", tag);
        end
    endtask

    task automatic test_start_held;
        capture(2'd1, 4'd2, 4'd1, 10, 1'b1);
        vectors++;
        if ({oa, ob, oc} !== {64'h202, 64'h28, 64'h80}) begin
            miscompares++;
            $display("FAIL held_abc: got a=%h b=%h c=%h want a=202 b=28 c=80", oa, ob, oc);
        end
        vectors++;
        if ({obusy, odone, oerr} !== {64'h6FE, 64'h80, 64'h0}) begin
            miscompares++;
            $display("FAIL held_stat: got busy=%h done=%h err=%h want 6fe 80 0", obusy, odone, oerr);
        end
        drain("held");
    endtask

    task automatic test_max;
        capture(2'd0, 4'd15, 4'd15, 20, 1'b0);
        vectors++;
        if (nb != 15 || fb != 3 || cc != 18) begin
            miscompares++;
            $display("FAIL max_consec: got nb=%0d first=%0d c=%0d want 15 3 18", nb, fb, cc);
        end
        capture(2'd1, 4'd15, 4'd15, 246, 1'b0);
        vectors++;
        if (nb != 15 || fb != 3 || cc != 243) begin
            miscompares++;
            $display("FAIL max_nonconsec: got nb=%0d first=%0d c=%0d want 15 3 243", nb, fb, cc);
        end
        capture(2'd2, 4'd15, 4'd15, 246, 1'b0);
        vectors++;
        if (nb != 15 || fb != 18 || cc != 243) begin
            miscompares++;
            $display("FAIL max_goto: got nb=%0d first=%0d c=%0d want 15 18 243", nb, fb, cc);
        end
        drain("max");
    endtask

    initial begin
        test_reset();
        test_consec();
        test_nonconsec();
        test_goto();
        test_gap_zero();
        test_invalid();
        test_mid_reset();
        test_start_held();
        test_max();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
